seq_mult_ctrl: RTL

Sequential shift-add multiplier controller for the arithmetic library. It computes an N×N product by reusing a single WIDTH-bit adder row over WIDTH clock cycles instead of instantiating a full array of adder cells. This trades latency for area next to the combinational array multiplier. A start/busy/done handshake lets a host issue one multiplication at a time.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_ctrl_rca_row.sv | 38 +++
 rtl/seq_mult_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential shift-add multiplier.
//   state_t        controller states (IDLE, CALC, DONE), 2-bit encoding
//   DEFAULT_WIDTH  default operand width
//   cnt_width()    width of the iteration counter for a given operand width
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_rca_row.sv
// rca_row: WIDTH-bit ripple-carry adder row with carry-in.
// Each bit is a full adder formed from two half-adder stages.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry into bit 0
//   sum   out WIDTH  sum bits
//   cout  out 1      carry out of the top bit
module rca_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder: a + b.
    assign ha1_s = a[gi] ^ b[gi];
    assign ha1_c = a[gi] & b[gi];
    // Second half adder: partial sum + incoming carry.
    assign sum[gi]      = ha1_s ^ carry[gi];
    assign ha2_c        = ha1_s & carry[gi];
    assign carry[gi+1]  = ha1_c | ha2_c;
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-add multiplier. One WIDTH-bit adder row is
// reused for WIDTH cycles to form a 2*WIDTH-bit product.
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands and
// product; otherwise the block multiplies unsigned numbers.
// Ports:
//   clk    in  1        rising-edge clock
//   rst_n  in  1        synchronous active-low reset
//   start  in  1        request, sampled only while idle
//   a      in  WIDTH    multiplicand, captured on the accepting edge
//   b      in  WIDTH    multiplier, captured on the accepting edge
//   busy   out 1        high whenever the block is not idle
//   done   out 1        one-cycle pulse, p holds the new product
//   p      out 2*WIDTH  product, held until the next done
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] p_reg;

  logic               last_iter;
  logic [WIDTH-1:0]   addend;
  logic               add_cin;
  logic [WIDTH-1:0]   row_sum;
  logic               row_cout;
  logic               sum_top;
  logic [2*WIDTH-1:0] shifted;

  assign last_iter = (cnt_reg == LAST_CNT);

  // Operand mux in front of the adder row.
`ifdef SEQ_MULT_SIGNED_EN
  logic sub_iter;
  // The multiplier's top bit carries negative weight, so the final partial
  // product is subtracted: acc + ~mcand + 1.
  assign sub_iter = last_iter & mplier_reg[0];
  always_comb begin
    addend = '0;
    if (mplier_reg[0]) begin
      addend = sub_iter ? ~mcand_reg : mcand_reg;
    end
  end
  assign add_cin = sub_iter;
  // Bit WIDTH of the sign-extended sum, not the raw carry out.
  assign sum_top = acc_reg[WIDTH-1] ^ addend[WIDTH-1] ^ row_cout;
`else
  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign add_cin = 1'b0;
  assign sum_top = row_cout;
`endif

  rca_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .a    (acc_reg),
    .b    (addend),
    .cin  (add_cin),
    .sum  (row_sum),
    .cout (row_cout)
  );

  // {top, sum, mplier} shifted right by one as a single word. The bit that
  // would shift into the carry position is always zero, so no flop is kept
  // for it and the consumed mplier[0] simply drops off the bottom.
  assign shifted = {sum_top, row_sum, mplier_reg[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      p_reg      <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        CALC: begin
          {acc_reg, mplier_reg} <= shifted;
          cnt_reg               <= cnt_reg + CNT_ONE;
          if (last_iter) begin
            p_reg <= shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p = p_reg;

endmodule
